// File: rtl/uart_pkg.sv
// Shared UART constants used as defaults by the UART datapath blocks.
package uart_pkg;

   localparam int UART_DATA_WIDTH    = 8;
   localparam int UART_TX_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding the UART transmitter; a push is visible on the read side the next cycle.
// Push refused while full (dropped, sticky ovf_o); rd_ready_i ignored while empty; flush clears level but not ovf_o.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH       = UART_DATA_WIDTH,
   parameter int BUFFER_DEPTH     = UART_TX_FIFO_DEPTH,
   parameter int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
   input  logic                        clk_i,
   input  logic                        rst_n_i,
   input  logic                        flush_i,
   input  logic                        wr_valid_i,
   output logic                        wr_ready_o,
   input  logic [DATA_WIDTH-1:0]       wr_data_i,
   output logic                        rd_valid_o,
   input  logic                        rd_ready_i,
   output logic [DATA_WIDTH-1:0]       rd_data_o,
   output logic [LOG_BUFFER_DEPTH:0]   cnt_o,
   output logic                        full_o,
   output logic                        empty_o,
   input  logic [LOG_BUFFER_DEPTH:0]   thresh_i,
   output logic                        irq_thresh_o,
   input  logic                        ovf_clr_i,
   output logic                        ovf_o
);

   localparam logic [LOG_BUFFER_DEPTH:0]   CNT_FULL = (LOG_BUFFER_DEPTH+1)'(BUFFER_DEPTH);
   localparam logic [LOG_BUFFER_DEPTH:0]   CNT_ONE  = (LOG_BUFFER_DEPTH+1)'(1);
   localparam logic [LOG_BUFFER_DEPTH-1:0] PTR_ONE  = (LOG_BUFFER_DEPTH)'(1);

   logic [DATA_WIDTH-1:0]       mem [BUFFER_DEPTH];
   logic [LOG_BUFFER_DEPTH-1:0] wr_ptr;
   logic [LOG_BUFFER_DEPTH-1:0] rd_ptr;
   logic [LOG_BUFFER_DEPTH:0]   cnt;
   logic                        ovf;
   logic                        push;
   logic                        pop;
   logic                        drop;

   assign full_o       = (cnt == CNT_FULL);
   assign empty_o      = (cnt == '0);
   assign wr_ready_o   = ~full_o;
   assign rd_valid_o   = ~empty_o;
   assign cnt_o        = cnt;
   assign ovf_o        = ovf;
   assign rd_data_o    = mem[rd_ptr];
   assign irq_thresh_o = (cnt <= thresh_i);

   // Flush discards any same-cycle handshake, including an overflowing push.
   assign push = wr_valid_i & wr_ready_o & ~flush_i;
   assign pop  = rd_valid_o & rd_ready_i & ~flush_i;
   assign drop = wr_valid_i & full_o & ~flush_i;

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + CNT_ONE;
            2'b01:   cnt <= cnt - CNT_ONE;
            default: cnt <= cnt;
         endcase
      end
   end

   // A drop in the same cycle as a clear request leaves the flag set.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ovf <= 1'b0;
      end else if (drop) begin
         ovf <= 1'b1;
      end else if (ovf_clr_i) begin
         ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomised stimulus for uart_tx_fifo, checked against a queue scoreboard and level model.
module tb_uart_tx_fifo;

   localparam int DEPTH = 16;

   logic       clk_i = 1'b0;
   logic       rst_n_i;
   logic       flush_i;
   logic       wr_valid_i;
   logic       wr_ready_o;
   logic [7:0] wr_data_i;
   logic       rd_valid_o;
   logic       rd_ready_i;
   logic [7:0] rd_data_o;
   logic [4:0] cnt_o;
   logic       full_o;
   logic       empty_o;
   logic [4:0] thresh_i;
   logic       irq_thresh_o;
   logic       ovf_clr_i;
   logic       ovf_o;

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] sb [$];
   int         mcnt;
   logic       movf;
   logic       last_push;
   logic       last_pop;
   int         pushed;
   int         popped;

   always #5 clk_i = ~clk_i;

   uart_tx_fifo dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .flush_i      (flush_i),
      .wr_valid_i   (wr_valid_i),
      .wr_ready_o   (wr_ready_o),
      .wr_data_i    (wr_data_i),
      .rd_valid_o   (rd_valid_o),
      .rd_ready_i   (rd_ready_i),
      .rd_data_o    (rd_data_o),
      .cnt_o        (cnt_o),
      .full_o       (full_o),
      .empty_o      (empty_o),
      .thresh_i     (thresh_i),
      .irq_thresh_o (irq_thresh_o),
      .ovf_clr_i    (ovf_clr_i),
      .ovf_o        (ovf_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag);
      chk({tag, ".cnt"},   32'(cnt_o), 32'(mcnt));
      chk({tag, ".empty"}, 32'(empty_o), 32'(mcnt == 0));
      chk({tag, ".full"},  32'(full_o), 32'(mcnt == DEPTH));
      chk({tag, ".wrrdy"}, 32'(wr_ready_o), 32'(mcnt != DEPTH));
      chk({tag, ".rdvld"}, 32'(rd_valid_o), 32'(mcnt != 0));
      chk({tag, ".ovf"},   32'(ovf_o), 32'(movf));
      chk({tag, ".irq"},   32'(irq_thresh_o), 32'(mcnt <= int'(thresh_i)));
   endtask

   // One clock cycle: drive, check head data before the edge, update the model, check after the edge.
   task automatic cycle(input logic wv, input logic [7:0] wd, input logic rr,
                        input logic fl, input logic clr, input string tag);
      logic pf;
      logic qf;
      flush_i    = fl;
      wr_valid_i = wv;
      wr_data_i  = wd;
      rd_ready_i = rr;
      ovf_clr_i  = clr;
      #1;
      pf = wv && (mcnt < DEPTH) && !fl;
      qf = rr && (mcnt > 0) && !fl;
      if (qf) chk({tag, ".rddata"}, 32'(rd_data_o), 32'(sb[0]));
      @(posedge clk_i);
      if (fl) begin
         sb.delete();
         mcnt = 0;
      end else begin
         if (qf) void'(sb.pop_front());
         if (pf) sb.push_back(wd);
         mcnt = mcnt + (pf ? 1 : 0) - (qf ? 1 : 0);
      end
      if (wv && (mcnt == DEPTH || (mcnt == DEPTH - 1 && qf)) && !pf && !fl) movf = 1'b1;
      else if (clr) movf = 1'b0;
      last_push = pf;
      last_pop  = qf;
      #1;
      flush_i = 1'b0; wr_valid_i = 1'b0; rd_ready_i = 1'b0; ovf_clr_i = 1'b0;
      chk_state(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n_i = 1'b0; flush_i = 1'b0; wr_valid_i = 1'b0; wr_data_i = 8'h00;
      rd_ready_i = 1'b0; ovf_clr_i = 1'b0; thresh_i = 5'd3;
      mcnt = 0; movf = 1'b0;
      @(posedge clk_i); #1;
      chk("rst.cnt", 32'(cnt_o), 32'd0);
      chk("rst.empty", 32'(empty_o), 32'd1);
      chk("rst.full", 32'(full_o), 32'd0);
      chk("rst.rdvld", 32'(rd_valid_o), 32'd0);
      chk("rst.wrrdy", 32'(wr_ready_o), 32'd1);
      chk("rst.ovf", 32'(ovf_o), 32'd0);
      chk("rst.irq", 32'(irq_thresh_o), 32'd1);
      #2 rst_n_i = 1'b1;
      @(posedge clk_i); #1;

      // Single byte latency
      cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, "one.push");
      chk("one.data", 32'(rd_data_o), 32'hA5);
      chk("one.cnt", 32'(cnt_o), 32'd1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "one.pop");
      chk("one.empty", 32'(empty_o), 32'd1);

      // Fill, overflow, drain in order, clear ovf
      for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, "fill");
      cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, "ovfpush");
      chk("ovf.full", 32'(full_o), 32'd1);
      chk("ovf.wrrdy", 32'(wr_ready_o), 32'd0);
      chk("ovf.flag", 32'(ovf_o), 32'd1);
      for (int i = 0; i < 16; i++) begin
         chk("drain.data", 32'(rd_data_o), 32'(i));
         cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain");
      end
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, "ovfclr");
      chk("ovfclr.flag", 32'(ovf_o), 32'd0);

      // Full with simultaneous push and pop
      for (int i = 0; i < 16; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b0, "fill2");
      cycle(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, "fullpp");
      chk("fullpp.cnt", 32'(cnt_o), 32'd15);
      for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "to5");
      cycle(1'b1, 8'h5C, 1'b1, 1'b0, 1'b0, "pp5");
      chk("pp5.cnt", 32'(cnt_o), 32'd5);
      while (mcnt > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, "drain2");

      // Random stream with wrap
      pushed = 0; popped = 0;
      for (int c = 0; c < 800 && (pushed < 40 || mcnt > 0); c++) begin
         cycle((pushed < 40) && ($urandom_range(0, 2) != 0), 8'h40 + 8'(pushed),
               1'($urandom_range(0, 1)), 1'b0, 1'b1, "stream");
         if (last_push) pushed++;
         if (last_pop) popped++;
      end
      chk("stream.pops", 32'(popped), 32'd40);

      // Low watermark at 2
      thresh_i = 5'd2;
      #1 chk("thr.c0", 32'(irq_thresh_o), 32'd1);
      cycle(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, "thr");
      chk("thr.c1", 32'(irq_thresh_o), 32'd1);
      cycle(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, "thr");
      chk("thr.c2", 32'(irq_thresh_o), 32'd1);
      cycle(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, "thr");
      chk("thr.c3", 32'(irq_thresh_o), 32'd0);
      cycle(1'b1, 8'h04, 1'b0, 1'b0, 1'b0, "thr");
      chk("thr.c4", 32'(irq_thresh_o), 32'd0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "thr");
      chk("thr.d3", 32'(irq_thresh_o), 32'd0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "thr");
      chk("thr.d2", 32'(irq_thresh_o), 32'd1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "thr");
      chk("thr.d1", 32'(irq_thresh_o), 32'd1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "thr");
      thresh_i = 5'd20;
      #1 chk("thr.big", 32'(irq_thresh_o), 32'd1);

      // Flush with 7 entries and a pending overflow flag
      for (int i = 0; i < 17; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0, "fill3");
      for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "to7");
      chk("pre.cnt", 32'(cnt_o), 32'd7);
      cycle(1'b1, 8'h33, 1'b0, 1'b1, 1'b0, "flush");
      chk("flush.cnt", 32'(cnt_o), 32'd0);
      chk("flush.empty", 32'(empty_o), 32'd1);
      chk("flush.ovf", 32'(ovf_o), 32'd1);
      cycle(1'b1, 8'h61, 1'b0, 1'b0, 1'b0, "post");
      cycle(1'b1, 8'h62, 1'b1, 1'b0, 1'b0, "post");
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "post");

      // Asynchronous reset mid-stream
      cycle(1'b1, 8'h71, 1'b0, 1'b0, 1'b0, "pre_rst");
      cycle(1'b1, 8'h72, 1'b0, 1'b0, 1'b0, "pre_rst");
      wr_valid_i = 1'b1; wr_data_i = 8'h73; rd_ready_i = 1'b1;
      #2 rst_n_i = 1'b0;
      #1;
      chk("arst.cnt", 32'(cnt_o), 32'd0);
      chk("arst.empty", 32'(empty_o), 32'd1);
      chk("arst.full", 32'(full_o), 32'd0);
      chk("arst.rdvld", 32'(rd_valid_o), 32'd0);
      chk("arst.wrrdy", 32'(wr_ready_o), 32'd1);
      chk("arst.ovf", 32'(ovf_o), 32'd0);
      chk("arst.irq", 32'(irq_thresh_o), 32'd1);
      wr_valid_i = 1'b0; rd_ready_i = 1'b0;
      sb.delete(); mcnt = 0; movf = 1'b0;
      @(posedge clk_i); #2 rst_n_i = 1'b1;
      @(posedge clk_i); #1;
      cycle(1'b1, 8'h9A, 1'b0, 1'b0, 1'b0, "after_rst");
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
